mpu_transpose_ctrl: RTL and testbench
=====================================

// Module: mpu_transpose_ctrl
// PURPOSE
//  Sequencer for the combinational MpuTranspose datapath. Collects a 5x5 signed
//  8-bit matrix as a 25-beat valid/ready byte stream, latches it, clocks the
//  transposed result into an output buffer and streams it out as 25 beats.
//  Sits between the MPU host byte bus and the transpose unit; one matrix in flight.
// PARAMETERS
//  ELEM_W   8   element width in bits; must equal the MpuTranspose element width
//  DIM      5   matrix dimension; fixed at 5, other values are unsupported
// PORTS
//  clk        in   1       single clock, rising edge
//  rst_n      in   1       asynchronous active-low reset
//  flush      in   1       synchronous abort, returns to IDLE
//  in_valid   in   1       input beat valid
//  in_ready   out  1       input beat accepted when in_valid & in_ready
//  in_data    in   ELEM_W  input element, row-major order (k = 5*row + col)
//  in_last    in   1       asserted by host on beat k=24 only
//  out_valid  out  1       output beat valid
//  out_ready  in   1       downstream accepts beat
//  out_data   out  ELEM_W  transposed element, row-major order
//  out_last   out  1       high with out_valid on beat k=24
//  done       out  1       1-cycle pulse after the final output handshake
//  err        out  1       1-cycle pulse on framing error
// BEHAVIOUR
//  - Reset: state IDLE, counters 0, buffers 0; in_ready=0 while rst_n low, then 1;
//    out_valid, out_last, done, err, out_data all 0.
//  - Element k of the flat bus occupies bits [8k +: 8]; result element 5r+c equals
//    input element 5c+r (diagonal unchanged).
//  - States: IDLE -> LOAD -> EXEC -> DRAIN -> IDLE.
//    IDLE : in_ready=1; handshake writes beat 0, cnt=1, go LOAD.
//    LOAD : in_ready=1; each handshake writes element cnt, cnt++. Handshake with
//           cnt=24 and in_last=1 -> EXEC.
//    EXEC : in_ready=0; exactly one cycle; register transpose output into result
//           buffer, cnt=0, go DRAIN.
//    DRAIN: out_valid=1, out_data=result[cnt], out_last=(cnt==24); cnt++ on
//           handshake; handshake on cnt=24 -> IDLE with done=1 next cycle.
//  - Latency: last input handshake at cycle T -> EXEC at T+1 -> first out_valid at
//    T+2. Minimum matrix period 51 cycles (25 in + 1 exec + 25 out).
//  - out_valid/out_data/out_last stable while out_valid & !out_ready.
//  - Framing: in_last=1 on any beat k<24, or in_last=0 on beat 24 -> err pulse next
//    cycle, partial matrix discarded, cnt=0, state IDLE. Both buffers untouched.
//  - in_ready is a function of state only (no combinational path from in_valid).
//  - flush: highest priority; any concurrent handshake is ignored, next cycle state
//    IDLE, cnt=0, out_valid=0, no done/err pulse. Buffer contents undefined.
//  - rst_n low mid-operation: immediate return to reset values, no pulses.
//  - done and err never assert in the same cycle.
// CONFIGURATION
//  MPU_CTRL_BYPASS_EN defined: adds input port bypass (1 bit), sampled on the beat-0
//  handshake; if 1, EXEC copies the input matrix unchanged to the result buffer
//  (out element k = in element k); latency and handshakes identical.
//  Undefined: no bypass port; result is always the transpose.
// TESTING
//  1 Load k=0..24 with in_data=k, out_ready=1 -> out stream 0,5,10,15,20,1,6,...,24;
//    out_last on beat 24; done one cycle later; first out_valid 2 cycles after beat 24.
//  2 Load signed values (-128 at k=1, 127 at k=5) -> out beat 1 = 127, beat 5 = -128.
//  3 Random out_ready backpressure (50%) -> out_data/out_last held while stalled,
//    sequence unchanged, exactly 25 handshakes, one done pulse.
//  4 in_last=1 on beat 10 -> err pulse, no out_valid, next full matrix transposes
//    correctly; separately in_last=0 on beat 24 -> err pulse, state IDLE.
//  5 flush asserted with in_valid on beat 12, and again during DRAIN beat 3 -> IDLE
//    next cycle, out_valid=0, no done; rst_n pulse mid-LOAD -> all outputs 0.
//  6 MPU_CTRL_BYPASS_EN, bypass=1, in_data=k -> out stream 0,1,2,...,24.

Source files
------------

// File: rtl/mpu_transpose_ctrl.sv
// mpu_transpose_ctrl: sequencer around a 5x5 signed-element transpose.
// Loads 25 row-major beats into an input buffer, spends one EXEC cycle
// registering the transposed matrix into a result buffer, then streams it out.
// Optional feature macro: MPU_CTRL_BYPASS_EN adds a `bypass` input that, when
// sampled high on beat 0, makes EXEC copy the matrix through unchanged.
module mpu_transpose_ctrl #(
    parameter int ELEM_W = 8,
    parameter int DIM    = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
`ifdef MPU_CTRL_BYPASS_EN
    input  logic              bypass,
`endif
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ELEM_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ELEM_W-1:0] out_data,
    output logic              out_last,
    output logic              done,
    output logic              err
);

    localparam int NUM    = DIM * DIM;
    localparam int CNT_W  = $clog2(NUM);
    localparam int FLAT_W = NUM * ELEM_W;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_EXEC,
        ST_DRAIN
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [FLAT_W-1:0]   in_buf_q, in_buf_d;
    logic [FLAT_W-1:0]   res_buf_q, res_buf_d;
    logic [FLAT_W-1:0]   xpose;
    logic                in_ready_q, in_ready_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                in_hs;
`ifdef MPU_CTRL_BYPASS_EN
    logic                bypass_q, bypass_d;
`endif

    // Combinational transpose datapath: result element (r,c) takes input (c,r).
    always_comb begin
        xpose = '0;
        for (int r = 0; r < DIM; r++) begin
            for (int c = 0; c < DIM; c++) begin
                xpose[(DIM*r + c)*ELEM_W +: ELEM_W] = in_buf_q[(DIM*c + r)*ELEM_W +: ELEM_W];
            end
        end
    end

    assign in_hs = in_valid && in_ready_q;

    // Next-state, counter, buffer-write and pulse logic; flush overrides everything.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_d   = state_q;
        cnt_d     = cnt_q;
        in_buf_d  = in_buf_q;
        res_buf_d = res_buf_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
`ifdef MPU_CTRL_BYPASS_EN
        bypass_d  = bypass_q;
`endif
        if (flush) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (in_hs) begin
                        if (in_last) begin
                            // Beat 0 can never be the last beat.
                            err_d = 1'b1;
                            cnt_d = '0;
                        end else begin
                            in_buf_d[0 +: ELEM_W] = in_data;
                            cnt_d                 = CNT_W'(1);
                            state_d               = ST_LOAD;
`ifdef MPU_CTRL_BYPASS_EN
                            bypass_d              = bypass;
`endif
                        end
                    end
                end
                ST_LOAD: begin
                    if (in_hs) begin
                        if (in_last != (cnt_q == LAST_IDX)) begin
                            // Framing error: drop the partial matrix, leave buffers as they are.
                            err_d   = 1'b1;
                            cnt_d   = '0;
                            state_d = ST_IDLE;
                        end else begin
                            in_buf_d[int'(cnt_q)*ELEM_W +: ELEM_W] = in_data;
                            if (cnt_q == LAST_IDX) begin
                                state_d = ST_EXEC;
                            end else begin
                                cnt_d = cnt_q + 1'b1;
                            end
                        end
                    end
                end
                ST_EXEC: begin
`ifdef MPU_CTRL_BYPASS_EN
                    res_buf_d = bypass_q ? in_buf_q : xpose;
`else
                    res_buf_d = xpose;
`endif
                    cnt_d     = '0;
                    state_d   = ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (out_ready) begin
                        if (cnt_q == LAST_IDX) begin
                            done_d  = 1'b1;
                            cnt_d   = '0;
                            state_d = ST_IDLE;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
        // in_ready is registered from the next state, so it never depends on in_valid.
        in_ready_d = (state_d == ST_IDLE) || (state_d == ST_LOAD);
    end

    // State, counter, buffers and pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the matrix buffers are reset too, so out_data and the result are defined zeros after reset.
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            in_buf_q   <= '0;
            res_buf_q  <= '0;
            in_ready_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef MPU_CTRL_BYPASS_EN
            bypass_q   <= 1'b0;
`endif
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            in_buf_q   <= in_buf_d;
            res_buf_q  <= res_buf_d;
            in_ready_q <= in_ready_d;
            done_q     <= done_d;
            err_q      <= err_d;
`ifdef MPU_CTRL_BYPASS_EN
            bypass_q   <= bypass_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q == ST_DRAIN);
    assign out_last  = out_valid && (cnt_q == LAST_IDX);
    assign out_data  = out_valid ? res_buf_q[int'(cnt_q)*ELEM_W +: ELEM_W] : '0;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mpu_transpose_ctrl.sv
// Self-checking bench for mpu_transpose_ctrl: table of matrix cases driven
// through a scoreboard, plus hand-written flush and reset sequences.
module tb_mpu_transpose_ctrl;

    localparam int N = 25;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = '0;
    logic       in_last = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       out_last;
    logic       done;
    logic       err;
`ifdef MPU_CTRL_BYPASS_EN
    logic       bypass = 1'b0;
`endif

    int tests = 0;
    int fails = 0;

    logic [7:0] exp_q [$];
    logic [7:0] cur_m [N];

    typedef struct {
        string name;
        int    pattern;   // 0 ramp, 1 signed extremes, 2 random
        int    frame_k;   // -1 good framing, else beat whose in_last is wrong
        int    rdy_pct;   // out_ready probability in percent
        bit    byp;       // expect pass-through instead of transpose
        bit    exp_err;   // expected framing error
    } vec_t;

    vec_t vecs [$];

    mpu_transpose_ctrl #(.ELEM_W(8), .DIM(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
`ifdef MPU_CTRL_BYPASS_EN
        .bypass    (bypass),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s: bound expired at %0t", name, $time);
    endtask

    task automatic fill(input int pattern);
        for (int k = 0; k < N; k++) begin
            case (pattern)
                0:       cur_m[k] = 8'(k);
                1:       cur_m[k] = (k == 1) ? 8'h80 : (k == 5) ? 8'h7f : 8'(k);
                default: cur_m[k] = 8'($urandom);
            endcase
        end
    endtask

    task automatic push_expected(input bit byp);
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 5; c++) begin
                exp_q.push_back(byp ? cur_m[5*r + c] : cur_m[5*c + r]);
            end
        end
    endtask

    // Sends beats first..last; in_last follows correct framing except on frame_k.
    task automatic send_beats(input int first, input int last, input int frame_k);
        for (int k = first; k <= last; k++) begin
            int w;
            in_valid = 1'b1;
            in_data  = cur_m[k];
            in_last  = (k == N - 1) ^ (k == frame_k);
            w = 0;
            while (!in_ready && w < 100) begin
                step();
                w++;
            end
            if (w == 100) begin
                fail_now("in_ready_wait");
                break;
            end
            step();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Drains one matrix against the scoreboard with random backpressure.
    task automatic drain(input int rdy_pct);
        int         hs;
        int         cyc;
        bit         stalled;
        bit         fin;
        logic [7:0] hd;
        logic       hl;
        logic [7:0] e;
        hs = 0;
        cyc = 0;
        stalled = 1'b0;
        while (cyc < 600) begin
            out_ready = ($urandom_range(99) < rdy_pct);
            if (stalled && out_valid) begin
                check("hold_data", out_data, hd);
                check("hold_last", out_last, hl);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL sb_underflow: extra beat %0h", out_data);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("out_data[%0d]", hs), out_data, e);
                end
                check($sformatf("out_last[%0d]", hs), out_last, (hs == N - 1));
                hs++;
            end
            stalled = out_valid && !out_ready;
            hd  = out_data;
            hl  = out_last;
            fin = out_valid && out_ready && out_last;
            step();
            cyc++;
            if (fin || done) check("done_timing", done, fin);
            if (done) break;
        end
        out_ready = 1'b0;
        if (cyc >= 600) fail_now("drain_done");
        check("hs_count", hs, N);
        check("sb_empty", exp_q.size(), 0);
        step();
        check("done_one_pulse", done, 1'b0);
        check("idle_after_done", out_valid, 1'b0);
    endtask

    task automatic run_case(input vec_t v);
        fill(v.pattern);
`ifdef MPU_CTRL_BYPASS_EN
        bypass = v.byp;
`endif
        if (v.exp_err) begin
            send_beats(0, (v.frame_k >= 0 && v.frame_k < N - 1) ? v.frame_k : N - 1, v.frame_k);
            check({v.name, "_err"}, err, 1'b1);
            check({v.name, "_err_done"}, done, 1'b0);
            check({v.name, "_err_idle"}, in_ready, 1'b1);
            step();
            check({v.name, "_err_pulse"}, err, 1'b0);
            check({v.name, "_err_noout"}, out_valid, 1'b0);
            step();
            check({v.name, "_err_noout2"}, out_valid, 1'b0);
        end else begin
            send_beats(0, N - 1, -1);
            push_expected(v.byp);
            check({v.name, "_exec_err"}, err, 1'b0);
            check({v.name, "_exec_valid"}, out_valid, 1'b0);
            check({v.name, "_exec_ready"}, in_ready, 1'b0);
            step();
            check({v.name, "_first_valid"}, out_valid, 1'b1);
            drain(v.rdy_pct);
        end
    endtask

    initial begin
        vecs.push_back('{name:"ramp",        pattern:0, frame_k:-1, rdy_pct:100, byp:1'b0, exp_err:1'b0});
        vecs.push_back('{name:"signed",      pattern:1, frame_k:-1, rdy_pct:100, byp:1'b0, exp_err:1'b0});
        vecs.push_back('{name:"rand_bp",     pattern:2, frame_k:-1, rdy_pct:50,  byp:1'b0, exp_err:1'b0});
        vecs.push_back('{name:"last_early",  pattern:0, frame_k:10, rdy_pct:100, byp:1'b0, exp_err:1'b1});
        vecs.push_back('{name:"after_err",   pattern:2, frame_k:-1, rdy_pct:100, byp:1'b0, exp_err:1'b0});
        vecs.push_back('{name:"last_miss",   pattern:0, frame_k:24, rdy_pct:100, byp:1'b0, exp_err:1'b1});
        vecs.push_back('{name:"ramp_bp",     pattern:0, frame_k:-1, rdy_pct:30,  byp:1'b0, exp_err:1'b0});
        vecs.push_back('{name:"beat0_last",  pattern:2, frame_k:0,  rdy_pct:100, byp:1'b0, exp_err:1'b1});
        vecs.push_back('{name:"after_err2",  pattern:1, frame_k:-1, rdy_pct:70,  byp:1'b0, exp_err:1'b0});
`ifdef MPU_CTRL_BYPASS_EN
        vecs.push_back('{name:"bypass",      pattern:0, frame_k:-1, rdy_pct:100, byp:1'b1, exp_err:1'b0});
        vecs.push_back('{name:"bypass_bp",   pattern:2, frame_k:-1, rdy_pct:50,  byp:1'b1, exp_err:1'b0});
        vecs.push_back('{name:"xpose_again", pattern:2, frame_k:-1, rdy_pct:100, byp:1'b0, exp_err:1'b0});
`endif

        // Reset state.
        step();
        step();
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_last", out_last, 1'b0);
        check("rst_out_data", out_data, 8'h00);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        rst_n = 1'b1;
        step();
        check("post_rst_ready", in_ready, 1'b1);

        foreach (vecs[i]) run_case(vecs[i]);

        // Flush with a concurrent input handshake on beat 12.
        fill(0);
        send_beats(0, 11, -1);
        in_valid = 1'b1;
        in_data  = cur_m[12];
        flush    = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_load_ready", in_ready, 1'b1);
        check("flush_load_valid", out_valid, 1'b0);
        check("flush_load_err", err, 1'b0);
        check("flush_load_done", done, 1'b0);
        run_case(vecs[0]);

        // Flush during DRAIN on output beat 3.
        fill(2);
        send_beats(0, N - 1, -1);
        push_expected(1'b0);
        step();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            logic [7:0] e;
            e = exp_q.pop_front();
            check($sformatf("pre_flush_data[%0d]", i), out_data, e);
            step();
        end
        check("pre_flush_valid", out_valid, 1'b1);
        flush = 1'b1;
        step();
        flush     = 1'b0;
        out_ready = 1'b0;
        exp_q.delete();
        check("flush_drain_valid", out_valid, 1'b0);
        check("flush_drain_last", out_last, 1'b0);
        check("flush_drain_done", done, 1'b0);
        check("flush_drain_ready", in_ready, 1'b1);
        step();
        check("flush_drain_done2", done, 1'b0);
        check("flush_drain_err2", err, 1'b0);
        run_case(vecs[2]);

        // Asynchronous reset pulse mid-LOAD.
        fill(0);
        send_beats(0, 7, -1);
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", in_ready, 1'b0);
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_out_data", out_data, 8'h00);
        check("midrst_out_last", out_last, 1'b0);
        check("midrst_done", done, 1'b0);
        check("midrst_err", err, 1'b0);
        step();
        step();
        rst_n = 1'b1;
        check("midrst_hold_ready", in_ready, 1'b0);
        step();
        check("midrst_ready", in_ready, 1'b1);
        check("midrst_no_err", err, 1'b0);
        run_case(vecs[1]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
